// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline stage: valid/ready handshake with optional skid entry,
// synchronous flush and a global stall hold. Head payload is fully registered.
module pipe_stage_elastic #(
    parameter int unsigned WIDTH   = 16,
    parameter bit          SKID_EN = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall_pipeline,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [1:0]       occupancy
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] main_data, skid_data;
    logic             main_valid, skid_valid;
    logic             in_xfer, out_xfer;
    logic             main_load, main_from_skid, skid_load;

    assign main_valid = (state_q != EMPTY);
    assign skid_valid = (state_q == SKID);

    // The skid variant keeps in_ready purely registered; the single-entry
    // variant lets a draining downstream free the slot in the same cycle.
    generate
        if (SKID_EN) begin : g_skid_ready
            assign in_ready = ~skid_valid & ~stall_pipeline & ~flush & ~reset;
        end else begin : g_pass_ready
            assign in_ready = (~main_valid | out_ready) & ~stall_pipeline & ~flush & ~reset;
        end
    endgenerate

    assign in_xfer   = in_valid & in_ready;
    assign out_xfer  = main_valid & out_ready & ~stall_pipeline;
    assign out_valid = main_valid;
    assign out_data  = main_data;
    assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};

    always_comb begin
        state_d        = state_q;
        main_load      = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        if (flush) begin
            state_d = EMPTY;
        end else if (!stall_pipeline) begin
            unique case (state_q)
                EMPTY: begin
                    if (in_xfer) begin
                        state_d   = FULL;
                        main_load = 1'b1;
                    end
                end
                FULL: begin
                    if (in_xfer && out_xfer) begin
                        main_load = 1'b1;
                    end else if (in_xfer && SKID_EN) begin
                        state_d   = SKID;
                        skid_load = 1'b1;
                    end else if (out_xfer) begin
                        state_d = EMPTY;
                    end
                end
                SKID: begin
                    if (out_xfer) begin
                        state_d        = FULL;
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= EMPTY;
            main_data <= '0;
            skid_data <= '0;
        end else begin
            state_q <= state_d;
            if (main_load) begin
                main_data <= main_from_skid ? skid_data : in_data;
            end
            if (skid_load) begin
                skid_data <= in_data;
            end
        end
    end

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Directed self-checking bench for pipe_stage_elastic: a skid instance (a)
// and a single-entry instance (b) exercised in turn with hand-computed values.
module tb_pipe_stage_elastic;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall_pipeline, flush;
    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [15:0] a_in_data, a_out_data;
    logic [1:0]  a_occupancy;
    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [15:0] b_in_data, b_out_data;
    logic [1:0]  b_occupancy;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipe_stage_elastic #(.WIDTH(16), .SKID_EN(1'b1)) dut_a (
        .clk(clk), .reset(reset), .stall_pipeline(stall_pipeline), .flush(flush),
        .in_valid(a_in_valid), .in_data(a_in_data), .in_ready(a_in_ready),
        .out_valid(a_out_valid), .out_data(a_out_data), .out_ready(a_out_ready),
        .occupancy(a_occupancy)
    );

    pipe_stage_elastic #(.WIDTH(16), .SKID_EN(1'b0)) dut_b (
        .clk(clk), .reset(reset), .stall_pipeline(stall_pipeline), .flush(flush),
        .in_valid(b_in_valid), .in_data(b_in_data), .in_ready(b_in_ready),
        .out_valid(b_out_valid), .out_data(b_out_data), .out_ready(b_out_ready),
        .occupancy(b_occupancy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; stall_pipeline = 1'b0; flush = 1'b0;
        a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b0;
        b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0;
        #2;
        check("rst_a_in_ready", a_in_ready, 0);
        check("rst_a_out_valid", a_out_valid, 0);
        check("rst_a_out_data", a_out_data, 0);
        check("rst_a_occ", a_occupancy, 0);
        check("rst_b_in_ready", b_in_ready, 0);
        check("rst_b_occ", b_occupancy, 0);
        tick(); tick();
        reset = 1'b0;

        // Streaming 1..8 with out_ready high
        a_in_valid = 1'b1; a_in_data = 16'h0001; a_out_ready = 1'b1;
        #2 check("stream_in_ready", a_in_ready, 1);
        tick();
        for (int k = 2; k <= 8; k++) begin
            a_in_data = 16'(k);
            #2;
            check("stream_data", a_out_data, k - 1);
            check("stream_valid", a_out_valid, 1);
            check("stream_occ", a_occupancy, 1);
            tick();
        end
        a_in_valid = 1'b0;
        #2 check("stream_last", a_out_data, 16'h0008);
        tick();
        check("stream_drained_occ", a_occupancy, 0);
        check("stream_drained_valid", a_out_valid, 0);

        // Backpressure into the skid entry
        a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_data = 16'hAAAA;
        tick();
        a_in_data = 16'hBBBB;
        #2 check("bp_ready_full", a_in_ready, 1);
        tick();
        a_in_valid = 1'b0;
        #2;
        check("bp_occ2", a_occupancy, 2);
        check("bp_ready_skid", a_in_ready, 0);
        check("bp_head", a_out_data, 16'hAAAA);
        a_out_ready = 1'b1;
        #1 check("bp_no_comb_path", a_in_ready, 0);
        tick();
        check("bp_second", a_out_data, 16'hBBBB);
        check("bp_occ1", a_occupancy, 1);
        check("bp_ready_back", a_in_ready, 1);
        tick();
        check("bp_empty", a_occupancy, 0);

        // Global stall holds a full stage
        a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_data = 16'h1234;
        tick();
        a_in_valid = 1'b0; a_out_ready = 1'b1; stall_pipeline = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #2;
            check("stall_ready", a_in_ready, 0);
            check("stall_data", a_out_data, 16'h1234);
            check("stall_occ", a_occupancy, 1);
            tick();
        end
        check("stall_held", a_occupancy, 1);
        stall_pipeline = 1'b0;
        #2 check("stall_release_ready", a_in_ready, 1);
        tick();
        check("stall_released_occ", a_occupancy, 0);

        // Flush at occupancy 2 with a competing input
        a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_data = 16'h1111;
        tick();
        a_in_data = 16'h2222;
        tick();
        check("flush_pre_occ", a_occupancy, 2);
        flush = 1'b1; a_in_data = 16'h3333;
        #2;
        check("flush_in_ready", a_in_ready, 0);
        check("flush_out_valid", a_out_valid, 1);
        tick();
        flush = 1'b0; a_in_valid = 1'b0;
        #2;
        check("flush_out_valid_after", a_out_valid, 0);
        check("flush_occ_after", a_occupancy, 0);
        tick();
        check("flush_nothing_taken", a_occupancy, 0);

        // Asynchronous reset mid-cycle at occupancy 2
        a_in_valid = 1'b1; a_in_data = 16'h5555;
        tick();
        a_in_data = 16'h6666;
        tick();
        a_in_valid = 1'b0;
        check("areset_pre_occ", a_occupancy, 2);
        #2 reset = 1'b1;
        #1;
        check("areset_valid", a_out_valid, 0);
        check("areset_data", a_out_data, 0);
        check("areset_occ", a_occupancy, 0);
        check("areset_ready", a_in_ready, 0);
        tick();
        reset = 1'b0;
        a_in_valid = 1'b1; a_in_data = 16'h7777;
        #2 check("areset_post_ready", a_in_ready, 1);
        tick();
        a_in_valid = 1'b0;
        check("areset_post_data", a_out_data, 16'h7777);
        check("areset_post_occ", a_occupancy, 1);
        a_out_ready = 1'b1;
        tick();

        // Single-entry variant: pass-through ready
        b_in_valid = 1'b1; b_in_data = 16'hC0DE; b_out_ready = 1'b0;
        #2 check("b_ready_empty", b_in_ready, 1);
        tick();
        b_in_data = 16'hBEEF;
        #2;
        check("b_ready_blocked", b_in_ready, 0);
        check("b_occ_full", b_occupancy, 1);
        tick();
        check("b_held", b_out_data, 16'hC0DE);
        check("b_occ_max", b_occupancy, 1);
        b_out_ready = 1'b1;
        #1 check("b_ready_same_cycle", b_in_ready, 1);
        tick();
        check("b_next", b_out_data, 16'hBEEF);
        check("b_occ_stream", b_occupancy, 1);
        b_in_data = 16'h0F0F;
        tick();
        b_in_valid = 1'b0;
        check("b_stream2", b_out_data, 16'h0F0F);
        tick();
        check("b_drained", b_occupancy, 0);
        check("b_drained_valid", b_out_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
